// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: states, opcodes,
// and the datapath mux/ALU select codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_B_REG = 2'b00;
    localparam logic [1:0] ALU_B_ONE = 2'b01;
    localparam logic [1:0] ALU_B_IMM = 2'b10;
    localparam logic [1:0] ALU_B_BR  = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // States whose exit back to FETCH retires an instruction.
    function automatic logic is_retire(state_e s);
        return s inside {S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB};
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle sequencer (master) and the datapath /
// memory side (slave).
interface multicycle_control_if #(parameter int STATE_W = 4);
    logic [5:0]         opcode;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond_eq;
    logic               pc_write_cond_neq;
    logic [1:0]         pc_source;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic [STATE_W-1:0] state;
    logic               err_illegal;
    logic               err_timeout;
    logic [31:0]        instr_count;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond_eq, pc_write_cond_neq, pc_source, i_or_d,
               mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
               alu_src_a, alu_src_b, alu_op, state, err_illegal, err_timeout,
               instr_count
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond_eq, pc_write_cond_neq, pc_source, i_or_d,
               mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
               alu_src_a, alu_src_b, alu_op, state, err_illegal, err_timeout,
               instr_count
    );
endinterface

// File: rtl/mc_wait_timer.sv
// Saturating count of memory-wait cycles in the current state, raising a
// sticky err_timeout once TIMEOUT_CYCLES is reached (0 disables it).
module mc_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic clear,
    output logic err_timeout
);
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST  = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          counting;

    assign counting = waiting && (TIMEOUT_CYCLES != 0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (clear)
                cnt <= '0;
            else if (counting && cnt != LIMIT)
                cnt <= cnt + CW'(1);
            // The cycle that completes the LIMIT-th wait sets the flag.
            if (counting && cnt == LAST)
                err_timeout <= 1'b1;
        end
    end
endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM sharing one ALU and one memory port.
// Optional retired-instruction counter: define MC_INSTR_COUNT_EN.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int STATE_W        = 4
) (
    input  logic clk,
    input  logic rst,
    multicycle_control_if.master bus
);
    state_e st, nxt;
    logic   legal, waiting, err_q;

    assign legal = bus.opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI};

    always_ff @(posedge clk) begin
        if (rst) st <= S_FETCH;
        else     st <= nxt;
    end

    always_comb begin
        nxt = S_FETCH;
        unique case (st)
            S_FETCH:     nxt = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (bus.opcode)
                    OP_LW, OP_SW:   nxt = S_MEM_ADDR;
                    OP_RTYPE:       nxt = S_EXECUTE;
                    OP_BEQ, OP_BNE: nxt = S_BRANCH;
                    OP_J:           nxt = S_JUMP;
                    OP_ADDI:        nxt = S_ADDI_EXEC;
                    default:        nxt = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  nxt = (bus.opcode == OP_LW) ? S_MEM_READ :
                               (bus.opcode == OP_SW) ? S_MEM_WRITE : S_FETCH;
            S_MEM_READ:  nxt = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: nxt = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   nxt = S_R_WB;
            S_ADDI_EXEC: nxt = S_ADDI_WB;
            default:     nxt = S_FETCH;
        endcase
    end

    always_comb begin
        bus.pc_write          = 1'b0;
        bus.pc_write_cond_eq  = 1'b0;
        bus.pc_write_cond_neq = 1'b0;
        bus.pc_source         = PC_SRC_ALU;
        bus.i_or_d            = 1'b0;
        bus.mem_read          = 1'b0;
        bus.mem_write         = 1'b0;
        bus.ir_write          = 1'b0;
        bus.mem_to_reg        = 1'b0;
        bus.reg_dst           = 1'b0;
        bus.reg_write         = 1'b0;
        bus.alu_src_a         = 1'b0;
        bus.alu_src_b         = ALU_B_REG;
        bus.alu_op            = ALU_ADD;
        bus.err_illegal       = 1'b0;
        // Reset masks every strobe so an aborted store never writes.
        if (!rst) begin
            unique case (st)
                S_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = ALU_B_ONE;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.alu_src_b   = ALU_B_BR;
                    bus.err_illegal = !legal;
                end
                S_MEM_ADDR, S_ADDI_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = ALU_B_IMM;
                end
                S_MEM_READ: begin
                    bus.mem_read = 1'b1;
                    bus.i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    bus.mem_write = 1'b1;
                    bus.i_or_d    = 1'b1;
                end
                S_EXECUTE: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = ALU_FUNCT;
                end
                S_R_WB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    bus.alu_src_a         = 1'b1;
                    bus.alu_op            = ALU_SUB;
                    bus.pc_source         = PC_SRC_ALUOUT;
                    bus.pc_write_cond_eq  = (bus.opcode == OP_BEQ);
                    bus.pc_write_cond_neq = (bus.opcode == OP_BNE);
                end
                S_JUMP: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = PC_SRC_JUMP;
                end
                S_ADDI_WB:   bus.reg_write = 1'b1;
                default: ;
            endcase
        end
    end

    assign waiting = (st inside {S_FETCH, S_MEM_READ, S_MEM_WRITE}) && !bus.mem_ready;

    mc_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
        .clk         (clk),
        .rst         (rst),
        .waiting     (waiting),
        .clear       (nxt != st),
        .err_timeout (err_q)
    );

    assign bus.err_timeout = err_q && !rst;
    assign bus.state       = STATE_W'(st);

`ifdef MC_INSTR_COUNT_EN
    logic [31:0] icnt;
    always_ff @(posedge clk) begin
        if (rst)
            icnt <= '0;
        else if (nxt == S_FETCH && is_retire(st))
            icnt <= icnt + 32'd1;
    end
    assign bus.instr_count = rst ? '0 : icnt;
`else
    assign bus.instr_count = '0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction phase lists and the state
// output table drive a reference model checked against the DUT every cycle.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst;

    multicycle_control_if #(.STATE_W(4)) bus ();

    multicycle_control #(.TIMEOUT_CYCLES(16), .STATE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       cond_eq;
        logic       cond_neq;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       err_illegal;
    } ctrl_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          cmp_en = 1'b0;
    ctrl_t       exp_ctrl, act_ctrl;
    int          exp_state;
    logic        exp_err;
    logic [31:0] exp_cnt;
    int          mcount;
    logic        merr;
    int          wcnt;

    assign act_ctrl = {bus.pc_write, bus.pc_write_cond_eq, bus.pc_write_cond_neq,
                       bus.pc_source, bus.i_or_d, bus.mem_read, bus.mem_write,
                       bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                       bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.err_illegal};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("state", 32'(bus.state), 32'(exp_state));
            chk("ctrl", 32'(act_ctrl), 32'(exp_ctrl));
            chk("err_timeout", 32'(bus.err_timeout), 32'(exp_err));
            chk("instr_count", bus.instr_count, exp_cnt);
        end
    end

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd8};
    endfunction

    function automatic logic [31:0] cnt_exp();
`ifdef MC_INSTR_COUNT_EN
        return 32'(mcount);
`else
        return 32'd0;
`endif
    endfunction

    // Output table by phase number.
    function automatic ctrl_t model(input int st, input logic [5:0] op, input logic rdy);
        ctrl_t c = '0;
        case (st)
            0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
            1:  begin c.alu_src_b = 2'b11; c.err_illegal = !legal(op); end
            2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            3:  begin c.mem_read = 1; c.i_or_d = 1; end
            4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
            5:  begin c.mem_write = 1; c.i_or_d = 1; end
            6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            7:  begin c.reg_write = 1; c.reg_dst = 1; end
            8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_source = 2'b01;
                      c.cond_eq = (op == 6'd4); c.cond_neq = (op == 6'd5); end
            9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
            10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            11: c.reg_write = 1;
            default: ;
        endcase
        return c;
    endfunction

    task automatic cycle(input int st, input logic rdy);
        bus.mem_ready = rdy;
        exp_state = st;
        exp_ctrl  = model(st, bus.opcode, rdy);
        exp_err   = merr;
        exp_cnt   = cnt_exp();
        cmp_en    = 1'b1;
        @(posedge clk); #1;
        if ((st == 0 || st == 3 || st == 5) && !rdy) begin
            wcnt++;
            if (wcnt == 16) merr = 1'b1;
        end
    endtask

    task automatic rst_cycle(input int st);
        rst       = 1'b1;
        exp_state = st;
        exp_ctrl  = '0;
        exp_err   = 1'b0;
        exp_cnt   = 32'd0;
        cmp_en    = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        merr   = 1'b0;
        mcount = 0;
    endtask

    // fw/mw: waits in FETCH / memory phase (-1 = random 0..3).
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit abort);
        int seq[$];
        int nw, st;
        bus.opcode = op;
        seq = {0, 1};
        case (op)
            6'd35: seq = {seq, 2, 3, 4};
            6'd43: seq = {seq, 2, 5};
            6'd0:  seq = {seq, 6, 7};
            6'd4, 6'd5: seq.push_back(8);
            6'd2:  seq.push_back(9);
            6'd8:  seq = {seq, 10, 11};
            default: ;
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            st   = seq[i];
            wcnt = 0;
            if (st == 0 || st == 3 || st == 5) begin
                nw = (st == 0) ? fw : mw;
                if (nw < 0) nw = int'($urandom_range(0, 3));
                repeat (nw) cycle(st, 1'b0);
                if (abort && st == 5) begin
                    rst_cycle(5);
                    return;
                end
                cycle(st, 1'b1);
            end else begin
                cycle(st, 1'($urandom_range(0, 1)));
            end
        end
        if (legal(op)) mcount++;
    endtask

    logic [5:0] ops [7];

    initial begin
        ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd8};
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        bus.opcode = 6'd0;
        mcount = 0;
        merr = 1'b0;
        wcnt = 0;
        @(posedge clk); #1;
        rst_cycle(0);

        run_instr(6'b000000, 0, 0, 0);
        chk("pin_r_state", 32'(bus.state), 32'd0);
`ifdef MC_INSTR_COUNT_EN
        chk("pin_r_count", bus.instr_count, 32'd1);
`else
        chk("pin_r_count", bus.instr_count, 32'd0);
`endif
        run_instr(6'b100011, 0, 3, 0);
        chk("pin_lw_err", 32'(bus.err_timeout), 32'd0);
        run_instr(6'b000100, 0, 0, 0);
        run_instr(6'b000101, 0, 0, 0);
        run_instr(6'b111111, 0, 0, 0);
`ifdef MC_INSTR_COUNT_EN
        chk("pin_illegal_count", bus.instr_count, 32'd4);
`else
        chk("pin_illegal_count", bus.instr_count, 32'd0);
`endif
        run_instr(6'b101011, 0, 20, 0);
        chk("pin_timeout_sticky", 32'(bus.err_timeout), 32'd1);

        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 5) == 0) run_instr(6'($urandom), -1, -1, 0);
            else run_instr(ops[$urandom_range(0, 6)], -1, -1, 0);
        end

        run_instr(6'b101011, 0, 2, 1);
        chk("pin_abort_state", 32'(bus.state), 32'd0);
        chk("pin_abort_count", bus.instr_count, 32'd0);
        chk("pin_abort_err", 32'(bus.err_timeout), 32'd0);
        run_instr(6'b000000, -1, -1, 0);
`ifdef MC_INSTR_COUNT_EN
        chk("pin_post_count", bus.instr_count, 32'd1);
`else
        chk("pin_post_count", bus.instr_count, 32'd0);
`endif
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the 32-bit MIPS datapath.
- Replaces the single-cycle combinational control unit with a state machine that time-shares one ALU and one unified memory port across instruction phases.
- Sequences FETCH, DECODE, EXECUTE, MEM and WB phases for R-type, lw, sw, beq, bne, addi and j.
- Holds in memory states on a ready handshake; reports illegal opcodes and memory timeouts.

Parameters:
TIMEOUT_CYCLES, 16, wait cycles in a memory state before err_timeout is set; 0 disables the check.
STATE_W, 4, state register width.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
opcode  input  6  instruction register bits [31:26]; stable after FETCH completes.
mem_ready  input  1  memory completes the current read/write in this cycle.
pc_write  output  1  unconditional PC load.
pc_write_cond_eq  output  1  PC load if ALU zero = 1.
pc_write_cond_neq  output  1  PC load if ALU zero = 0.
pc_source  output  2  00 = ALU result, 01 = ALUOut register, 10 = jump address {pc[31:26], instr[25:0]}.
i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
mem_read  output  1  memory read strobe.
mem_write  output  1  memory write strobe.
ir_write  output  1  instruction register load.
mem_to_reg  output  1  register write data: 0 = ALUOut, 1 = MDR.
reg_dst  output  1  write register: 0 = rt [20:16], 1 = rd [15:11].
reg_write  output  1  register file write enable.
alu_src_a  output  1  ALU a input: 0 = PC, 1 = readData1.
alu_src_b  output  2  ALU b input: 00 = readData2, 01 = constant 1, 10 = sign-extended immediate, 11 = sign-extended immediate (branch offset).
alu_op  output  2  to the ALU control block: 00 = add, 01 = subtract, 10 = use funct field.
state  output  STATE_W  current state, for debug.
err_illegal  output  1  one-cycle pulse in DECODE for an unknown opcode.
err_timeout  output  1  sticky; cleared only by rst.
instr_count  output  32  retired-instruction count; see Optional Feature.

Behaviour:
- Reset: while rst = 1, the next state is FETCH and every output except state is forced to 0. instr_count clears, err_timeout clears and the wait counter clears. In the first cycle after reset, state = FETCH (0).
- Outputs are decoded from the state register and default to 0. The only input-dependent outputs are ir_write and pc_write in FETCH, and the cond_eq/cond_neq outputs in BRANCH.
- Opcodes: R-type = 000000, lw = 100011, sw = 101011, beq = 000100, bne = 000101, j = 000010, addi = 001000.
- Per-state outputs and transitions:
  - FETCH (0): mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00; ir_write = pc_write = mem_ready. Goes to DECODE when mem_ready = 1, otherwise holds.
  - DECODE (1): alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut). Next state by opcode: lw/sw -> MEM_ADDR, R-type -> EXECUTE, beq/bne -> BRANCH, j -> JUMP, addi -> ADDI_EXEC, anything else -> FETCH with err_illegal = 1.
  - MEM_ADDR (2): alu_src_a = 1, alu_src_b = 10, alu_op = 00. Goes to MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ (3): mem_read = 1, i_or_d = 1. Goes to MEM_WB when mem_ready = 1.
  - MEM_WB (4): reg_write = 1, reg_dst = 0, mem_to_reg = 1. Goes to FETCH.
  - MEM_WRITE (5): mem_write = 1, i_or_d = 1. Goes to FETCH when mem_ready = 1. mem_write stays asserted while waiting.
  - EXECUTE (6): alu_src_a = 1, alu_src_b = 00, alu_op = 10. Goes to R_WB.
  - R_WB (7): reg_write = 1, reg_dst = 1, mem_to_reg = 0. Goes to FETCH.
  - BRANCH (8): alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_source = 01; pc_write_cond_eq = (opcode == beq), pc_write_cond_neq = (opcode == bne). Goes to FETCH.
  - JUMP (9): pc_write = 1, pc_source = 10. Goes to FETCH.
  - ADDI_EXEC (10): alu_src_a = 1, alu_src_b = 10, alu_op = 00. Goes to ADDI_WB.
  - ADDI_WB (11): reg_write = 1, reg_dst = 0, mem_to_reg = 0. Goes to FETCH.
  - Unused encodings go to FETCH.
- Latency with mem_ready tied to 1: lw 5 cycles; R-type, sw and addi 4; beq, bne and j 3; illegal opcode 2 (treated as a NOP, PC already incremented).
- Wait counter:
  - Counts cycles spent in FETCH, MEM_READ or MEM_WRITE with mem_ready = 0. Clears on every state change.
  - When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), err_timeout is set; the FSM keeps waiting.
  - The counter saturates and does not wrap.
- rst mid-instruction, including in a wait state, aborts the instruction with no write strobe in the reset cycle.

Optional Feature:
- Macro: MC_INSTR_COUNT_EN.
- Defined: instr_count increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP or ADDI_WB. Illegal-opcode returns to FETCH do not count. The counter wraps 0xFFFFFFFF -> 0.
- Undefined: no counter register is built and instr_count is tied to 0.

Decomposition:
- Package mc_pkg: state encoding constants, opcode constants, alu_src_b / pc_source / alu_op encodings.
- Sub-module mc_wait_timer: saturating wait counter plus sticky err_timeout, with inputs clk, rst, waiting, clear.

Test Plan:
- rst = 1 for 2 cycles, then opcode = 000000 with mem_ready = 1 -> state sequence 0, 1, 6, 7, 0; reg_write = 1 and reg_dst = 1 only in state 7; instr_count = 1.
- lw (100011) with mem_ready = 0 for 3 cycles in MEM_READ -> state stays 3 with mem_read = 1 and i_or_d = 1 for 4 cycles; MEM_WB then asserts mem_to_reg = 1; err_timeout = 0.
- beq (000100) -> in state 8: pc_write_cond_eq = 1, pc_write_cond_neq = 0, pc_source = 01, alu_op = 01. bne (000101) -> the cond_eq/cond_neq values swap.
- Opcode 111111 -> err_illegal pulses for 1 cycle in state 1; next state 0; instr_count unchanged.
- sw (101011) with mem_ready held at 0 for 20 cycles, TIMEOUT_CYCLES = 16 -> err_timeout rises after 16 waiting cycles and stays high after mem_ready = 1; it clears only on rst.
- rst asserted while in MEM_WRITE -> in the reset cycle mem_write = 0 and reg_write = 0; in the next cycle state = 0 and instr_count = 0.
